stopwatch_timer: RTL



---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/bcd_digit_counter.sv | 29 ++
 rtl/stopwatch_timer.sv | 87 ++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch timebase and BCD time counter.
package stopwatch_pkg;

   localparam int BCD_W = 4;

   // Largest legal value of each digit position.
   localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;
   localparam logic [BCD_W-1:0] CS_MAX       = 4'd9;
   localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
   localparam logic [BCD_W-1:0] MIN_TENS_MAX = 4'd5;

   // Default timebase: DE10-Lite 50 MHz clock, centisecond resolution.
   localparam int DEF_CLK_HZ  = 50_000_000;
   localparam int DEF_TICK_HZ = 100;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the time cascade: counts 0..MAX, wraps to 0 and emits a
// combinational carry so the whole chain settles in a single cycle.
module bcd_digit_counter
   import stopwatch_pkg::*;
#(
   parameter logic [BCD_W-1:0] MAX = DIGIT_MAX
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [BCD_W-1:0] q,
   output logic             carry
);

   // Anything at or above MAX wraps, so a corrupted digit self-heals to 0.
   assign carry = inc && (q >= MAX);

   // Digit register: clear beats increment; otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= '0;
      else if (clr)
         q <= '0;
      else if (inc)
         q <= carry ? '0 : q + BCD_W'(1);
   end

endmodule

// File: rtl/stopwatch_timer.sv
// Centisecond prescaler plus a six-digit MM:SS.cc BCD counter feeding the
// seven-segment display stage.
module stopwatch_timer
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ  = DEF_CLK_HZ,
   parameter int TICK_HZ = DEF_TICK_HZ
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             counting,
   input  logic             reset_timer,
   output logic [BCD_W-1:0] cs_ones,
   output logic [BCD_W-1:0] cs_tens,
   output logic [BCD_W-1:0] sec_ones,
   output logic [BCD_W-1:0] sec_tens,
   output logic [BCD_W-1:0] min_ones,
   output logic [BCD_W-1:0] min_tens,
   output logic             tick,
   output logic             rollover
);

   localparam int DIV   = CLK_HZ / TICK_HZ;
   localparam int PRE_W = $clog2(DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

   logic [PRE_W-1:0] prescaler;
   logic             advance;
   logic [5:0]       carry;

   // reset_timer gates advance, so it outranks counting everywhere downstream.
   assign advance = counting && !reset_timer && (prescaler == PRE_LAST);

   // Prescaler: clear, count while enabled, hold while paused so a partial
   // tick survives a pause.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         prescaler <= '0;
      else if (reset_timer)
         prescaler <= '0;
      else if (counting)
         prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + PRE_W'(1);
   end

   bcd_digit_counter #(.MAX(CS_MAX)) u_cs_ones (
      .clk(clk), .rst_n(rst_n), .clr(reset_timer), .inc(advance),
      .q(cs_ones), .carry(carry[0])
   );

   bcd_digit_counter #(.MAX(DIGIT_MAX)) u_cs_tens (
      .clk(clk), .rst_n(rst_n), .clr(reset_timer), .inc(carry[0]),
      .q(cs_tens), .carry(carry[1])
   );

   bcd_digit_counter #(.MAX(DIGIT_MAX)) u_sec_ones (
      .clk(clk), .rst_n(rst_n), .clr(reset_timer), .inc(carry[1]),
      .q(sec_ones), .carry(carry[2])
   );

   bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
      .clk(clk), .rst_n(rst_n), .clr(reset_timer), .inc(carry[2]),
      .q(sec_tens), .carry(carry[3])
   );

   bcd_digit_counter #(.MAX(DIGIT_MAX)) u_min_ones (
      .clk(clk), .rst_n(rst_n), .clr(reset_timer), .inc(carry[3]),
      .q(min_ones), .carry(carry[4])
   );

   bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
      .clk(clk), .rst_n(rst_n), .clr(reset_timer), .inc(carry[4]),
      .q(min_tens), .carry(carry[5])
   );

   // Status pulses registered alongside the digits so they line up with the
   // updated time; the top-digit carry is the 59:59.99 wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick     <= 1'b0;
         rollover <= 1'b0;
      end else begin
         tick     <= advance;
         rollover <= carry[5];
      end
   end

endmodule
